conv_window_fetch: RTL
======================

Name: conv_window_fetch

Overview:
Initiator side of the 3x3 convolution datapath. It scans every valid output position (i, j) of an H x W signed 8-bit image held in a synchronous-read image memory and fetches the nine taps of each window. It then presents the window, with i, j and an add strobe, to the convolution compute unit. Each window is held until the downstream side accepts it.

Parameters:
W, 28, image width in pixels; 3 <= W <= 32
H, 28, image height in pixels; 3 <= H <= 32
ADDR_LEN, 9, MSB index of image memory address; H*W <= 2^(ADDR_LEN+1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  frame start request; sampled only in IDLE
ready  input  1  downstream accepts the presented window this cycle
mem_rdata  input  8 signed  image memory read data; 1-cycle read latency
mem_en  output  1  image memory read enable
mem_addr  output  ADDR_LEN+1  image memory read address
image_data0..image_data8  output  8 signed each  window taps, row-major: tap 3r+c = pixel (i+r, j+c)
i  output  5  window row index, 0..H-3
j  output  5  window column index, 0..W-3
add  output  1  window valid strobe to compute unit
busy  output  1  frame in progress
done  output  1  one-cycle pulse after the last window is accepted

Behaviour:
- Clocking: single clock clk. rst is asynchronous and active-high.
- Reset: all outputs are 0, state is IDLE, and the tap counter and i/j counters are 0. A reset mid-frame abandons the frame immediately, with no done pulse.
- States: IDLE, FETCH, LAST, VALID, DONE.
- IDLE:
  - busy=0, add=0, mem_en=0.
  - start=1 at a clock edge: i=0, j=0, tap counter k=0, then go to FETCH.
- FETCH (9 cycles):
  - mem_en=1, mem_addr=(i+r)*W+(j+c) for k=3r+c, with k running 0..8, one per cycle.
  - Each cycle, mem_rdata is registered into image_data(k-1) (none on the first FETCH cycle).
  - After k=8, go to LAST.
- LAST (1 cycle): mem_en=0; register mem_rdata into image_data8; go to VALID.
- VALID:
  - add=1; image_data0..8, i and j are stable; mem_en=0 and mem_addr holds its last value.
  - A transfer occurs at an edge with add=1 and ready=1.
  - On transfer, if j<W-3: j=j+1, go to FETCH.
  - On transfer, if j=W-3 and i<H-3: j=0, i=i+1, go to FETCH.
  - On transfer, if i=H-3 and j=W-3: go to DONE.
  - While ready=0, VALID is held indefinitely with all outputs frozen.
- DONE: done=1 and busy=1 for one cycle, then go to IDLE. i, j and image_data hold their final values.
- busy=1 in FETCH, LAST, VALID and DONE.
- Timing:
  - Start sampled at edge E0: first FETCH cycle is cycle 1, first add is in cycle 11.
  - With ready held at 1, windows are 11 cycles apart.
- Address arithmetic: unsigned, computed at ADDR_LEN+1 bits, never wraps for legal parameters. Taps are passed through unmodified (signed 8-bit), with no scaling.
- start while busy=1 is ignored. start and ready are don't-care outside IDLE and VALID respectively.
- Between windows (FETCH/LAST) add=0 and image_data registers update progressively. Consumers must sample them only when add=1.

Test Plan:
- Reset: assert rst asynchronously mid-FETCH -> same cycle: add=0, busy=0, done=0, mem_en=0, mem_addr=0, i=j=0, all image_data=0; state IDLE after release.
- First window (W=H=28, mem[a]=a mod 128, ready=1): start pulse at E0 -> mem_addr is 0,1,2,28,29,30,56,57,58 in cycles 1-9 with mem_en=1; add=1 in cycle 11 with image_data0..8 = 0,1,2,28,29,30,56,57,58 and i=0, j=0.
- Row wrap: transfer of window (0,25) -> next add has i=1, j=0; first FETCH address is 28 and last is 86.
- Backpressure: ready=0 for 5 cycles while window (0,3) is presented -> add stays 1 and image_data/i/j stay constant; mem_en=0; FETCH of (0,4) starts the cycle after ready returns to 1.
- Full frame, ready=1: exactly 676 transfers; last window has i=25, j=25 with addresses 725..783; last add is in cycle 7436; done=1 only in cycle 7437; busy=0 from cycle 7438.
- start pulsed during VALID of window (2,7) -> ignored: scan continues unchanged with no counter reset.

Source files
------------

// File: rtl/conv_window_fetch.sv
// Raster scan of every 3x3 window of an H x W signed 8-bit image: fetch nine
// taps from a 1-cycle-latency memory, then hold the window until it is accepted.
module conv_window_fetch #(
  parameter int W        = 28,
  parameter int H        = 28,
  parameter int ADDR_LEN = 9
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                ready,
  input  logic signed [7:0]   mem_rdata,
  output logic                mem_en,
  output logic [ADDR_LEN:0]   mem_addr,
  output logic signed [7:0]   image_data0,
  output logic signed [7:0]   image_data1,
  output logic signed [7:0]   image_data2,
  output logic signed [7:0]   image_data3,
  output logic signed [7:0]   image_data4,
  output logic signed [7:0]   image_data5,
  output logic signed [7:0]   image_data6,
  output logic signed [7:0]   image_data7,
  output logic signed [7:0]   image_data8,
  output logic [4:0]          i,
  output logic [4:0]          j,
  output logic                add,
  output logic                busy,
  output logic                done
);

  localparam int AW = ADDR_LEN + 1;

  // Handshake: a window transfers on a rising edge where add=1 and ready=1;
  // while ready=0 the presented window and all outputs stay frozen.
  typedef enum logic [2:0] {IDLE, FETCH, LAST, VALID, DONE} state_t;
  state_t state, state_nxt;

  logic [3:0]        k;
  logic [1:0]        r;
  logic [1:0]        c;
  logic signed [7:0] taps [9];
  logic              last_col;
  logic              last_row;
  logic [AW-1:0]     row_a;
  logic [AW-1:0]     col_a;

  assign last_col = (j == 5'(W - 3));
  assign last_row = (i == 5'(H - 3));

  // k stays at 8 after the fetch, so the address holds its last value
  assign row_a    = AW'(i) + AW'(r);
  assign col_a    = AW'(j) + AW'(c);
  assign mem_addr = row_a * AW'(W) + col_a;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = FETCH;
      FETCH: if (k == 4'd8) state_nxt = LAST;
      LAST:  state_nxt = VALID;
      VALID: if (ready) state_nxt = (last_col && last_row) ? DONE : FETCH;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_en = (state == FETCH);
    add    = (state == VALID);
    done   = (state == DONE);
    busy   = (state != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i <= '0;
      j <= '0;
      k <= '0;
      r <= '0;
      c <= '0;
      for (int n = 0; n < 9; n++) taps[n] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            i <= '0;
            j <= '0;
            k <= '0;
            r <= '0;
            c <= '0;
          end
        end
        FETCH: begin
          // read data lags the address by one cycle
          if (k != 4'd0) taps[k - 4'd1] <= mem_rdata;
          if (k != 4'd8) begin
            k <= k + 4'd1;
            if (c == 2'd2) begin
              c <= '0;
              r <= r + 2'd1;
            end else begin
              c <= c + 2'd1;
            end
          end
        end
        LAST: taps[8] <= mem_rdata;
        VALID: begin
          if (ready && !(last_col && last_row)) begin
            k <= '0;
            r <= '0;
            c <= '0;
            if (!last_col) begin
              j <= j + 5'd1;
            end else begin
              j <= '0;
              i <= i + 5'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign image_data0 = taps[0];
  assign image_data1 = taps[1];
  assign image_data2 = taps[2];
  assign image_data3 = taps[3];
  assign image_data4 = taps[4];
  assign image_data5 = taps[5];
  assign image_data6 = taps[6];
  assign image_data7 = taps[7];
  assign image_data8 = taps[8];

endmodule
